// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and width helpers for the UART transmit scheduler.
package uart_pkg;

   // Scheduler FSM: arbitrate, strobe the serializer, wait for busy to rise, then fall.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LAUNCH     = 2'd1,
      WAIT_START = 2'd2,
      WAIT_END   = 2'd3
   } sched_state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int ID_W        = $clog2(NUM_REQ_DEF);

   // Requester index width; never below one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Timeout counter only has to hold 0 .. TIMEOUT-1.
   function automatic int tmo_cnt_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and UART_TX facing signals of the scheduler, bundled.
// slave = scheduler view, master = requesters plus serializer view.
interface uart_tx_scheduler_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
) ();

   localparam int GID_W = id_width(NUM_REQ);

   // requester side
   logic [NUM_REQ-1:0]            REQ;
   logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
   logic [NUM_REQ-1:0]            REQ_PAR_EN;
   logic [NUM_REQ-1:0]            REQ_PAR_TYP;
   logic [NUM_REQ-1:0]            ACK;
   logic [NUM_REQ-1:0]            DONE;
   logic [GID_W-1:0]              GNT_ID;
   logic                          ACTIVE;
   logic                          ERR;
   logic                          ERR_CLR;

   // serializer side
   logic [DATA_WIDTH-1:0]         P_DATA;
   logic                          Data_valid;
   logic                          PAR_EN;
   logic                          PAR_TYP;
   logic                          busy;

   modport slave (
      input  REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, ERR_CLR, busy,
      output ACK, DONE, GNT_ID, ACTIVE, ERR, P_DATA, Data_valid, PAR_EN, PAR_TYP
   );

   modport master (
      output REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, ERR_CLR, busy,
      input  ACK, DONE, GNT_ID, ACTIVE, ERR, P_DATA, Data_valid, PAR_EN, PAR_TYP
   );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module uart_rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GID_W   = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GID_W-1:0]   ptr,
   output logic               gnt_valid,
   output logic [GID_W-1:0]   gnt_id
);

   logic [GID_W:0]   sum;
   logic [GID_W-1:0] idx;

   // Scan offsets from farthest to nearest so the requester closest to ptr wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      sum       = '0;
      idx       = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + (GID_W + 1)'(i);
         if (sum >= (GID_W + 1)'(NUM_REQ)) sum = sum - (GID_W + 1)'(NUM_REQ);
         idx = sum[GID_W-1:0];
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_id    = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART_TX among NUM_REQ byte requesters, round-robin.
// Latches the winner's byte/parity config, strobes Data_valid once, then follows
// the serializer's busy flag to produce per-requester ACK and DONE pulses.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                 CLK,
   input  logic                 RST,
   uart_tx_scheduler_if.slave   bus
);

   localparam int GID_W  = id_width(NUM_REQ);
   localparam int TCNT_W = tmo_cnt_width(TIMEOUT);

   sched_state_t                         state, state_nxt;
   logic [GID_W-1:0]                     ptr, ptr_nxt, gnt_id_q, arb_id;
   logic                                 arb_valid;
   logic [TCNT_W-1:0]                    tcnt;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_bytes;
   logic [DATA_WIDTH-1:0]                data_q;
   logic                                 pen_q, ptyp_q, err_q;
   logic [NUM_REQ-1:0]                   ack_q, done_q, owner_oh;
   logic                                 grant, started, ended, tmo_hit;

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ), .GID_W(GID_W)) u_arb (
      .req       (bus.REQ),
      .ptr       (ptr),
      .gnt_valid (arb_valid),
      .gnt_id    (arb_id)
   );

   assign req_bytes = bus.REQ_DATA;
   assign owner_oh  = NUM_REQ'(1) << gnt_id_q;
   assign ptr_nxt   = (gnt_id_q == GID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

   // A busy serializer in IDLE belongs to someone else; never launch over it.
   assign grant   = (state == IDLE) && arb_valid && !bus.busy;
   assign started = (state == WAIT_START) && bus.busy;
   assign ended   = (state == WAIT_END) && !bus.busy;
   assign tmo_hit = (state == WAIT_START) && !bus.busy && (tcnt == TCNT_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (grant) state_nxt = LAUNCH;
         LAUNCH:     state_nxt = WAIT_START;
         WAIT_START: begin
            if (bus.busy)     state_nxt = WAIT_END;
            else if (tmo_hit) state_nxt = IDLE;
         end
         WAIT_END:   if (!bus.busy) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs: launch strobe and ownership flag.
   always_comb begin
      bus.Data_valid = 1'b0;
      bus.ACTIVE     = 1'b0;
      case (state)
         LAUNCH: begin
            bus.Data_valid = 1'b1;
            bus.ACTIVE     = 1'b1;
         end
         WAIT_START, WAIT_END: bus.ACTIVE = 1'b1;
         default: ;
      endcase
   end

   // Latch the winner's byte and parity config; held until the next grant.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         gnt_id_q <= '0;
         data_q   <= '0;
         pen_q    <= 1'b0;
         ptyp_q   <= 1'b0;
      end else if (grant) begin
         gnt_id_q <= arb_id;
         data_q   <= req_bytes[arb_id];
         pen_q    <= bus.REQ_PAR_EN[arb_id];
         ptyp_q   <= bus.REQ_PAR_TYP[arb_id];
      end
   end

   // Round-robin pointer moves past the owner when its frame ends or times out.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                ptr <= '0;
      else if (ended || tmo_hit) ptr <= ptr_nxt;
   end

   // Cycles spent in WAIT_START without busy; restarted on every launch.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                                tcnt <= '0;
      else if (state == LAUNCH)                tcnt <= '0;
      else if (state == WAIT_START && !bus.busy) tcnt <= tcnt + 1'b1;
   end

   // One-cycle ACK when busy rises, DONE when it falls, both to the owner.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ack_q  <= '0;
         done_q <= '0;
      end else begin
         ack_q  <= started ? owner_oh : '0;
         done_q <= ended   ? owner_oh : '0;
      end
   end

   // Sticky timeout flag; a new timeout beats a simultaneous clear.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)             err_q <= 1'b0;
      else if (tmo_hit)     err_q <= 1'b1;
      else if (bus.ERR_CLR) err_q <= 1'b0;
   end

   assign bus.ACK     = ack_q;
   assign bus.DONE    = done_q;
   assign bus.GNT_ID  = gnt_id_q;
   assign bus.ERR     = err_q;
   assign bus.P_DATA  = data_q;
   assign bus.PAR_EN  = pen_q;
   assign bus.PAR_TYP = ptyp_q;

endmodule
